// File: rtl/ghost_pkg.sv
// ghost_pkg
//  Shared types and constants for the ghost sprite generator.
//  - ghost_state_t : frightened-mode FSM state (NORMAL=0, FRIGHT=1, BLINK=2)
//  - pal_sel_t     : palette selector carried down the pixel pipeline
//  - palette colour constants and the sprite edge length
//  - pal_lookup    : colour index + palette selector -> 12-bit RGB
package ghost_pkg;

    typedef enum logic [1:0] {
        NORMAL = 2'd0,
        FRIGHT = 2'd1,
        BLINK  = 2'd2
    } ghost_state_t;

    // BLINK in its even phase looks exactly like FRIGHT, so only three
    // palettes exist.
    typedef enum logic [1:0] {
        PAL_NORMAL    = 2'd0,
        PAL_FRIGHT    = 2'd1,
        PAL_BLINK_ODD = 2'd2
    } pal_sel_t;

    localparam int          SPRITE_SIZE    = 16;

    localparam logic [11:0] C_BLACK        = 12'h000;
    localparam logic [11:0] C_WHITE        = 12'hFFF;
    localparam logic [11:0] C_FRIGHT_BLUE  = 12'h00F;
    localparam logic [11:0] C_PUPIL        = 12'h22F;
    localparam logic [11:0] C_FRIGHT_PUPIL = 12'hF88;
    localparam logic [11:0] C_BLINK_RED    = 12'hF00;

    // Index 00 is transparent; the caller masks it with the hit flag.
    function automatic logic [11:0] pal_lookup(input pal_sel_t    sel,
                                               input logic [1:0]  idx,
                                               input logic [11:0] body);
        logic [11:0] c;
        c = C_BLACK;
        case (idx)
            2'b01: begin
                case (sel)
                    PAL_NORMAL:    c = body;
                    PAL_BLINK_ODD: c = C_WHITE;
                    default:       c = C_FRIGHT_BLUE;
                endcase
            end
            2'b10: c = C_WHITE;
            2'b11: begin
                case (sel)
                    PAL_NORMAL:    c = C_PUPIL;
                    PAL_BLINK_ODD: c = C_BLINK_RED;
                    default:       c = C_FRIGHT_PUPIL;
                endcase
            end
            default: c = C_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ghost_ram_lut.sv
// ghost_ram_lut
//  Simple dual-port bitmap store: one synchronous write port, one
//  synchronous read port with one cycle of read latency.
//  A read and a write to the same address in the same cycle return the
//  old contents (read-before-write).
//  Ports:
//   i_clk    clock
//   i_we     write enable
//   i_waddr  write address
//   i_wdata  write data
//   i_raddr  read address
//   o_rdata  read data, valid the cycle after i_raddr
module ghost_ram_lut #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ghost_sprite_src.sv
// ghost_sprite_src
//  Per-pixel ghost sprite generator. Maps scan position (x,y) to a bitmap
//  address, reads the 2-bit colour index from the bitmap RAM and turns it
//  into an RGB pixel plus hit flag, two cycles after (x,y) is presented.
//  Also owns the frightened-mode timer FSM and the walk-animation counter.
//  Ports:
//   i_clk, i_reset        clock, synchronous active-high reset
//   i_x, i_y              current scan pixel
//   i_x0, i_y0            sprite top-left corner
//   i_frame_tick          one pulse per video frame
//   i_fright_start        enter / restart frightened mode
//   i_ghost_color         body colour in NORMAL mode
//   i_bm_we/addr/data     bitmap write port
//   o_sprite_rgb          pixel colour (0 when not hit)
//   o_sprite_hit          pixel inside sprite and index != 0
//   o_fright_state        FSM state (NORMAL=0, FRIGHT=1, BLINK=2)
module ghost_sprite_src
    import ghost_pkg::*;
#(
    parameter int CD           = 12,
    parameter int ANIM_DIV     = 8,
    parameter int FRIGHT_TICKS = 360,
    parameter int BLINK_TICKS  = 120
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic [10:0]   i_x,
    input  logic [10:0]   i_y,
    input  logic [10:0]   i_x0,
    input  logic [10:0]   i_y0,
    input  logic          i_frame_tick,
    input  logic          i_fright_start,
    input  logic [CD-1:0] i_ghost_color,
    input  logic          i_bm_we,
    input  logic [9:0]    i_bm_addr,
    input  logic [1:0]    i_bm_data,
    output logic [CD-1:0] o_sprite_rgb,
    output logic          o_sprite_hit,
    output logic [1:0]    o_fright_state
);

    localparam int SB   = $clog2(SPRITE_SIZE);
    localparam int AW   = $clog2((ANIM_DIV > 1) ? ANIM_DIV : 2);
    localparam int TMAX = (FRIGHT_TICKS > BLINK_TICKS) ? FRIGHT_TICKS : BLINK_TICKS;
    localparam int TW   = $clog2(TMAX + 1);

    // ---------------- animation counter ----------------
    logic [AW-1:0] r_tick_cnt;
    logic          r_anim_frame;
    logic          r_blink_phase;
    logic          w_anim_wrap;

    assign w_anim_wrap = i_frame_tick && (r_tick_cnt == AW'(ANIM_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tick_cnt    <= '0;
            r_anim_frame  <= 1'b0;
            r_blink_phase <= 1'b0;
        end else if (i_frame_tick) begin
            if (w_anim_wrap) begin
                r_tick_cnt    <= '0;
                r_anim_frame  <= ~r_anim_frame;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_tick_cnt <= r_tick_cnt + AW'(1);
            end
        end
    end

    // ---------------- frightened-mode FSM ----------------
    ghost_state_t r_state, w_state_nxt;
    logic [TW-1:0] r_timer, w_timer_nxt;
    logic          w_fright_sel;
    pal_sel_t      w_pal_sel;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= NORMAL;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // fright_start is checked first so a restart beats a same-cycle expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        if (i_fright_start) begin
            w_state_nxt = FRIGHT;
            w_timer_nxt = '0;
        end else if (i_frame_tick) begin
            case (r_state)
                FRIGHT: begin
                    if (r_timer == TW'(FRIGHT_TICKS - 1)) begin
                        w_state_nxt = BLINK;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                BLINK: begin
                    if (r_timer == TW'(BLINK_TICKS - 1)) begin
                        w_state_nxt = NORMAL;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                NORMAL:  w_state_nxt = NORMAL;
                default: begin
                    w_state_nxt = NORMAL;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_fright_sel = 1'b0;
        w_pal_sel    = PAL_NORMAL;
        case (r_state)
            FRIGHT: begin
                w_fright_sel = 1'b1;
                w_pal_sel    = PAL_FRIGHT;
            end
            BLINK: begin
                w_fright_sel = 1'b1;
                w_pal_sel    = r_blink_phase ? PAL_BLINK_ODD : PAL_FRIGHT;
            end
            default: ;
        endcase
    end

    assign o_fright_state = r_state;

    // ---------------- stage 0: region test and address ----------------
    // The extra top bit catches x < x0 as a borrow, so the sprite never
    // wraps around the right edge of the coordinate space.
    logic [11:0] w_dx, w_dy;
    logic        w_inside;
    logic [9:0]  w_addr;

    assign w_dx     = {1'b0, i_x} - {1'b0, i_x0};
    assign w_dy     = {1'b0, i_y} - {1'b0, i_y0};
    assign w_inside = (w_dx[11:SB] == '0) && (w_dy[11:SB] == '0);
    assign w_addr   = {w_fright_sel, r_anim_frame, w_dy[SB-1:0], w_dx[SB-1:0]};

    // ---------------- stage 1: RAM read, side-band aligned ----------------
    logic       r_inside1;
    pal_sel_t   r_pal1;
    logic [1:0] w_idx;

    ghost_ram_lut #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(2)
    ) u_bitmap (
        .i_clk   (i_clk),
        .i_we    (i_bm_we),
        .i_waddr (i_bm_addr),
        .i_wdata (i_bm_data),
        .i_raddr (w_addr),
        .o_rdata (w_idx)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_inside1 <= 1'b0;
            r_pal1    <= PAL_NORMAL;
        end else begin
            r_inside1 <= w_inside;
            r_pal1    <= w_pal_sel;
        end
    end

    // ---------------- stage 2: colour and hit ----------------
    logic          w_hit;
    logic [CD-1:0] r_rgb;
    logic          r_hit;

    assign w_hit = r_inside1 && (w_idx != 2'b00);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rgb <= '0;
            r_hit <= 1'b0;
        end else begin
            r_hit <= w_hit;
            r_rgb <= w_hit ? CD'(pal_lookup(r_pal1, w_idx, 12'(i_ghost_color))) : '0;
        end
    end

    assign o_sprite_rgb = r_rgb;
    assign o_sprite_hit = r_hit;

endmodule
